// File: rtl/register_file.sv
// rtl/register_file.sv - 32-entry register file, two combinational reads, one synchronous write
module register_file #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic [4:0]       writeAd,
    input  logic             writeCntrl,
    input  logic [4:0]       readReg1,
    input  logic [4:0]       readReg2,
    output logic [WIDTH-1:0] read1,
    output logic [WIDTH-1:0] read2
);

    // Entry 0 exists only to keep indexing simple; it is never written and is masked on read.
    logic [WIDTH-1:0] mem [32];

    // Storage update: asynchronous clear, then gated write that skips address 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (writeCntrl && (writeAd != 5'd0)) begin
            mem[writeAd] <= data;
        end
    end

    // Read ports: purely combinational, no write bypass, register 0 forced to zero.
    always_comb begin
        read1 = '0;
        read2 = '0;
        if (readReg1 != 5'd0) begin
            read1 = mem[readReg1];
        end
        if (readReg2 != 5'd0) begin
            read2 = mem[readReg2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed table-driven bench for register_file
module tb_register_file;

    logic        clk;
    logic        reset;
    logic [31:0] data;
    logic [4:0]  writeAd;
    logic        writeCntrl;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [31:0] read1;
    logic [31:0] read2;

    int n_vec;
    int n_err;

    register_file #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .writeAd    (writeAd),
        .writeCntrl (writeCntrl),
        .readReg1   (readReg1),
        .readReg2   (readReg2),
        .read1      (read1),
        .read2      (read2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] d;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] d,
                         input logic [4:0] r1, input logic [4:0] r2);
        writeCntrl = we;
        writeAd    = wa;
        data       = d;
        readReg1   = r1;
        readReg2   = r2;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  32'h00000000, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd7,  32'h12345678, 5'd7,  5'd7,  32'h00000000, 32'h00000000};
        vecs[3] = '{1'b0, 5'd7,  32'h12345678, 5'd7,  5'd0,  32'h00000000, 32'h00000000};
        vecs[4] = '{1'b0, 5'd7,  32'h12345678, 5'd5,  5'd7,  32'hDEADBEEF, 32'h00000000};
        vecs[5] = '{1'b1, 5'd3,  32'h00000001, 5'd3,  5'd5,  32'h00000001, 32'hDEADBEEF};
        vecs[6] = '{1'b1, 5'd31, 32'hAAAA5555, 5'd31, 5'd3,  32'hAAAA5555, 32'h00000001};
        vecs[7] = '{1'b1, 5'd1,  32'h00000011, 5'd1,  5'd31, 32'h00000011, 32'hAAAA5555};
        vecs[8] = '{1'b1, 5'd5,  32'h00000000, 5'd5,  5'd1,  32'h00000000, 32'h00000011};
        vecs[9] = '{1'b0, 5'd1,  32'hFFFFFFFF, 5'd1,  5'd5,  32'h00000011, 32'h00000000};

        // Reset / idle
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        reset = 1'b1;
        #100;
        readReg1 = 5'd0;  readReg2 = 5'd5;  #1;
        check("reset_r1_a0", read1, 32'h0);
        check("reset_r2_a5", read2, 32'h0);
        readReg1 = 5'd31; readReg2 = 5'd31; #1;
        check("reset_r1_a31", read1, 32'h0);
        check("reset_r2_a31", read2, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven vectors: drive on negedge, check just after the following posedge
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].wa, vecs[i].d, vecs[i].r1, vecs[i].r2);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_read1", i), read1, vecs[i].e1);
            check($sformatf("vec%0d_read2", i), read2, vecs[i].e2);
        end

        // Same-cycle read/write of reg 3: old value before edge, new after
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h00000002, 5'd3, 5'd3);
        #1;
        check("rw_pre_edge_read1", read1, 32'h00000001);
        check("rw_pre_edge_read2", read2, 32'h00000001);
        @(posedge clk);
        #1;
        check("rw_post_edge_read1", read1, 32'h00000002);

        // Fill regs 1..31 with their index
        for (int a = 1; a < 32; a++) begin
            @(negedge clk);
            drive(1'b1, a[4:0], 32'(a), 5'd0, 5'd0);
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd17, 5'd31);
        #1;
        check("fill_read1_r17", read1, 32'd17);
        check("fill_read2_r31", read2, 32'd31);

        // Asynchronous reset between edges clears without a clock edge
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_read1_r17", read1, 32'h0);
        check("async_rst_read2_r31", read2, 32'h0);

        // Write pending while reset held over an edge is dropped
        drive(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd2);
        @(posedge clk);
        #1;
        check("rst_wins_read1_r9", read1, 32'h0);
        check("rst_wins_read2_r2", read2, 32'h0);

        // Deassert at negedge; first write accepted on the next rising edge
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 5'd31, 32'h000000A5, 5'd31, 5'd9);
        #1;
        check("post_rst_pre_edge_r31", read1, 32'h0);
        @(posedge clk);
        #1;
        check("post_rst_read1_r31", read1, 32'h000000A5);
        check("post_rst_read2_r9", read2, 32'h0);

        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
